// File: rtl/dff_pipe.sv
// Parameterised D register stage / delay line with clock enable, synchronous reset
// and a valid flag that rises once the pipe holds only captured data.
module dff_pipe #(
  parameter int                     WIDTH     = 1,
  parameter int                     DEPTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  // Declaration initialisers give the power-up state without needing a reset pulse.
  logic [WIDTH-1:0] stage_r [DEPTH] = '{default: RESET_VAL};
  logic [CW-1:0]    fill_r          = {CW{1'b0}};
  logic             q_valid_r       = 1'b0;

  // Shift register: reset fill, enabled shift, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RESET_VAL;
      end
    end else if (en) begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Saturating fill counter; q_valid is registered so it switches on the same edge as q.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_r    <= {CW{1'b0}};
      q_valid_r <= 1'b0;
    end else if (en) begin
      if (fill_r != FULL) begin
        fill_r <= fill_r + CW'(1'b1);
      end
      q_valid_r <= (fill_r >= (FULL - CW'(1'b1)));
    end
  end

  assign q       = stage_r[DEPTH-1];
  assign q_valid = q_valid_r;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: default 1-bit instance plus an 8-bit, 3-deep
// instance, directed scenarios followed by random stimulus against a queue model.
module tb_dff_pipe;

  localparam int         DEPTH8 = 3;
  localparam logic [7:0] RV8    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       d1  = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic       q1;
  logic       v1;
  logic [7:0] q8;
  logic       v8;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: values captured since the last reset, newest at the back, trimmed to DEPTH.
  logic       hist1 [$];
  logic [7:0] hist8 [$];

  dff_pipe u_dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d1), .q(q1), .q_valid(v1)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(DEPTH8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .d(d8), .q(q8), .q_valid(v8)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_q1();
    return (hist1.size() == 1) ? hist1[0] : 1'b0;
  endfunction

  function automatic logic [7:0] model_q8();
    return (hist8.size() == DEPTH8) ? hist8[0] : RV8;
  endfunction

  task automatic model_compare(input string tag);
    check_value({tag, ".q1"}, {31'd0, q1}, {31'd0, model_q1()});
    check_value({tag, ".v1"}, {31'd0, v1}, {31'd0, (hist1.size() == 1)});
    check_value({tag, ".q8"}, {24'd0, q8}, {24'd0, model_q8()});
    check_value({tag, ".v8"}, {31'd0, v8}, {31'd0, (hist8.size() == DEPTH8)});
  endtask

  // One rising edge with the given inputs, model update, then compare after the falling edge.
  task automatic step(input logic r, input logic e, input logic a1, input logic [7:0] a8,
                      input string tag);
    rst = r; en = e; d1 = a1; d8 = a8;
    @(posedge clk);
    if (r) begin
      hist1.delete();
      hist8.delete();
    end else if (e) begin
      hist1.push_back(a1);
      hist8.push_back(a8);
      if (hist1.size() > 1) void'(hist1.pop_front());
      if (hist8.size() > DEPTH8) void'(hist8.pop_front());
    end
    @(negedge clk);
    model_compare(tag);
  endtask

  initial begin
    // Power-up, before any edge
    #1;
    check_value("pwr.q1", {31'd0, q1}, 32'd0);
    check_value("pwr.v1", {31'd0, v1}, 32'd0);
    check_value("pwr.q8", {24'd0, q8}, {24'd0, RV8});
    check_value("pwr.v8", {31'd0, v8}, 32'd0);

    // Basic sequence on the single-bit flop
    step(1'b0, 1'b1, 1'b0, 8'h00, "seq0");  check_value("seq0.k", {31'd0, q1}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 8'h00, "seq1");  check_value("seq1.k", {31'd0, q1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00, "seqc");
      check_value("seqc.k", {31'd0, q1}, 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, "seq2");  check_value("seq2.k", {31'd0, q1}, 32'd0);

    // Hold with en low
    step(1'b0, 1'b1, 1'b1, 8'h10, "hld0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'hFF, "hold");
      check_value("hold.k", {31'd0, q1}, 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 8'h11, "hld1");  check_value("hld1.k", {31'd0, q1}, 32'd0);

    // Reset beats enable
    step(1'b0, 1'b1, 1'b1, 8'h12, "rp0");
    step(1'b1, 1'b1, 1'b1, 8'h13, "rp1");
    check_value("rp1.q", {31'd0, q1}, 32'd0);
    check_value("rp1.v", {31'd0, v1}, 32'd0);
    check_value("rp1.q8", {24'd0, q8}, {24'd0, RV8});
    step(1'b0, 1'b1, 1'b1, 8'h01, "rp2");
    check_value("rp2.q", {31'd0, q1}, 32'd1);
    check_value("rp2.v", {31'd0, v1}, 32'd1);

    // 8-bit, 3-deep latency (rp2 was the first enabled edge after reset)
    check_value("w8.e1", {23'd0, v8, q8}, {23'd0, 1'b0, RV8});
    step(1'b0, 1'b1, 1'b0, 8'h02, "w8b");
    check_value("w8.e2", {23'd0, v8, q8}, {23'd0, 1'b0, RV8});
    step(1'b0, 1'b1, 1'b0, 8'h03, "w8c");
    check_value("w8.e3", {23'd0, v8, q8}, {23'd0, 1'b1, 8'h01});
    step(1'b0, 1'b1, 1'b0, 8'h04, "w8d");
    check_value("w8.e4", {24'd0, q8}, 32'h02);
    step(1'b0, 1'b1, 1'b0, 8'h05, "w8e");
    check_value("w8.e5", {24'd0, q8}, 32'h03);

    // Reset mid-stream, then refill
    step(1'b1, 1'b0, 1'b0, 8'h00, "ms0");
    step(1'b0, 1'b1, 1'b0, 8'h31, "ms1");
    step(1'b0, 1'b1, 1'b0, 8'h32, "ms2");
    step(1'b1, 1'b0, 1'b0, 8'h33, "ms3");
    check_value("ms.q8", {24'd0, q8}, {24'd0, RV8});
    check_value("ms.v8", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h41, "mf1");  check_value("mf1.v8", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h99, "mfh");  check_value("mfh.v8", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h42, "mf2");  check_value("mf2.v8", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h43, "mf3");
    check_value("mf3.v8", {31'd0, v8}, 32'd1);
    check_value("mf3.q8", {24'd0, q8}, 32'h41);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
           1'($urandom), 8'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
